df_multiplier_pipe: RTL
=======================

# df_multiplier_pipe

Pipelined, parametrised unsigned coefficient multiplier for the digital-filter datapath; successor to the fixed 5-bit-coefficient combinational multiplier. Computes `(data * coef) >> FRAC_W` as a shift-add pipeline with one partial product per stage, giving one result per clock. A valid/ready handshake with a global stall connects it between the tap shift register and the accumulator. Overflow handling (saturate or wrap) is selected at compile time.

## Interface
- `DATA_W`, 8: sample width, unsigned.
- `COEF_W`, 5: coefficient width, unsigned; also the number of shift-add stages.
- `FRAC_W`, 4: fractional bits of coef; product is right-shifted by this amount. Legal range 0..COEF_W.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data`/`in_coef` are valid this cycle.
- `in_ready`  out  1  block accepts input this cycle.
- `in_data`  in  DATA_W  sample.
- `in_coef`  in  COEF_W  coefficient.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_data`  out  DATA_W  scaled product.

## Operation
- Partial product i = `data & {DATA_W{coef[i]}}` shifted left by i; accumulator width DATA_W+COEF_W bits, so no intermediate overflow.
- Stage 0 registers data, coef, valid bit, and acc = pp0.
- Stage k (1..COEF_W-1) registers acc + pp_k, passing data, coef and valid forward.
- Output stage registers `acc >> FRAC_W`, reduced to DATA_W bits per Configuration, plus `out_valid`.
- Global advance enable: `adv = !(out_valid && !out_ready)`. `in_ready = adv`. All stages, including valid bits, shift only when adv=1.
- Input is accepted when `in_valid && in_ready`. When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Bubbles are not collapsed; throughput is 1 result/cycle while out_ready stays high.
- Data/coef registers of invalid stages are don't-care but must not be X-propagating into valid results.

## Timing
- Latency: COEF_W+1 cycles from accepted input edge to `out_valid`=1 (6 cycles at defaults), with no stall.
- Stall: while out_valid=1 and out_ready=0, `out_data` and all pipeline contents hold exactly. in_ready=0 during the stall.
- Release: the result completes on the first edge with out_ready=1. The pipeline advances on that same edge, so in_ready=1 in the release cycle (same-cycle pass-through, no dead cycle).
- Reset: on a rising edge with reset=1, every valid bit is cleared, `out_valid`=0 and `out_data`=0. The accumulator, data and coef registers are cleared to 0. `in_ready`=1 in the cycle after reset.
- Reset during operation discards all in-flight samples. No output is produced for them.
- Reset has priority over the stall and over input acceptance.
- coef=0 produces 0. coef=2^FRAC_W produces data unchanged (unity gain).

## Configuration
- `DF_MUL_SAT_EN` defined: if `acc >> FRAC_W` exceeds 2^DATA_W−1, `out_data` = all ones. Otherwise it takes the low DATA_W bits.
- Undefined: `out_data` = low DATA_W bits of `acc >> FRAC_W` (wrap, modulo 2^DATA_W), with no comparator logic.
- Latency and handshake are identical in both builds.

## Test plan
Defaults (DATA_W=8, COEF_W=5, FRAC_W=4), out_ready=1 unless stated.
- Sweep: data=0xFF, coef=0..31 on consecutive cycles with in_valid=1.
  - Expect 32 results, each 6 cycles after its input.
  - coef=0 → 0x00; coef=8 → 0x7F; coef=16 → 0xFF.
  - coef=31 → 0xFF with DF_MUL_SAT_EN, 0xEE without.
  - Compare every result against the reference model `(data*coef)>>4`, saturated or wrapped per build.
- Random: 1000 random data/coef pairs with random in_valid gaps. Outputs must appear in order, and each must match the model.
- Stall: fill the pipeline, then drop out_ready for 10 cycles.
  - out_data and out_valid hold; in_ready=0 throughout.
  - After out_ready rises, the remaining results drain in order with no loss or duplication.
- Reset mid-flight: send 3 samples, then assert reset 2 cycles later.
  - Next cycle: out_valid=0, out_data=0, in_ready=1.
  - None of the 3 results ever appear.
- Unity gain and zero: data=0xA5, coef=16 → 0xA5; data=0xA5, coef=0 → 0x00. Run both builds.

Source files
------------

// File: rtl/df_multiplier_pipe.sv
// Pipelined unsigned shift-add coefficient multiplier: out = (data * coef) >> FRAC_W, one result per clock.
// Define DF_MUL_SAT_EN to saturate overflowing results; otherwise the result wraps modulo 2^DATA_W.
module df_multiplier_pipe #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 5,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int ACC_W = DATA_W + COEF_W;

    logic              adv;
    logic [COEF_W-1:0] valid_q;
    logic [DATA_W-1:0] data_q [COEF_W];
    logic [COEF_W-1:0] coef_q [COEF_W];
    logic [ACC_W-1:0]  acc_q  [COEF_W];
    logic [ACC_W-1:0]  acc_d  [COEF_W];
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;

    // One global enable: the whole pipe freezes only while a finished result is refused.
    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv;

    assign acc_d[0] = in_coef[0] ? ACC_W'(in_data) : '0;

    for (genvar k = 1; k < COEF_W; k++) begin : g_stage
        assign acc_d[k] = acc_q[k-1]
                        + (coef_q[k-1][k] ? (ACC_W'(data_q[k-1]) << k) : '0);
    end

`ifdef DF_MUL_SAT_EN
    logic [ACC_W-1:0] scaled;
    assign scaled     = acc_q[COEF_W-1] >> FRAC_W;
    assign out_data_d = (scaled > ACC_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}}
                                                           : scaled[DATA_W-1:0];
`else
    assign out_data_d = DATA_W'(acc_q[COEF_W-1] >> FRAC_W);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < COEF_W; k++) begin
                data_q[k] <= '0;
                coef_q[k] <= '0;
                acc_q[k]  <= '0;
            end
        end else if (adv) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            coef_q[0]  <= in_coef;
            acc_q[0]   <= acc_d[0];
            for (int k = 1; k < COEF_W; k++) begin
                valid_q[k] <= valid_q[k-1];
                data_q[k]  <= data_q[k-1];
                coef_q[k]  <= coef_q[k-1];
                acc_q[k]   <= acc_d[k];
            end
            out_valid_q <= valid_q[COEF_W-1];
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
